// File: rtl/rp_axis_server.sv
// rp_axis_server: Pi-facing command/response engine for the accelerometer link.
// Synchronises the Pi strobe/CS/data, decodes a one-byte axis command and returns
// the selected 16-bit sample as low byte then high byte on the shared bus.
// Optional build macro: RP_AXIS_STATUS_EN adds the 's' status command and the
// per-axis fresh flags it reports.
module rp_axis_server #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_50,
  input  logic        iRSTN,
  input  logic        RP_clock,
  input  logic        RP_CS,
  input  logic [7:0]  rp_data_in,
  output logic [7:0]  rp_data_out,
  output logic        rp_data_oe,
  input  logic        acc_valid,
  input  logic [1:0]  acc_axis,
  input  logic [15:0] acc_data,
  output logic [1:0]  dimension,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_L = 2'd1,
    SEND_H = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] rpclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic                   rpclk_dly_q;

  logic [15:0] ax_x_q, ax_y_q, ax_z_q;
  logic [15:0] snap_q, snap_d;
  state_t      state_q;
  logic [7:0]  rp_data_out_q;
  logic        rp_data_oe_q;
  logic [1:0]  dimension_q;
  logic        cmd_err_q;

  logic       rpclk_s, cs_s, strobe_edge, cmd_fire, bad_cmd;
  logic [7:0] data_s;
  logic [2:0] wr_sel, take_sel;
  logic       status_cmd;

`ifdef RP_AXIS_STATUS_EN
  logic [2:0] fresh_q;
  logic       status_q;
`endif

  // Pin synchronisers plus the strobe delay flop; strobe/CS reset high so a
  // pin that is already high at reset release does not look like an edge.
  always_ff @(posedge CLK_50) begin
    if (!iRSTN) begin
      rpclk_sync_q <= '1;
      cs_sync_q    <= '1;
      rpclk_dly_q  <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      rpclk_sync_q   <= {rpclk_sync_q[SYNC_STAGES-2:0], RP_clock};
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], RP_CS};
      rpclk_dly_q    <= rpclk_s;
      data_sync_q[0] <= rp_data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign rpclk_s     = rpclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign strobe_edge = rpclk_s & ~rpclk_dly_q;

  assign wr_sel = {acc_valid & (acc_axis == 2'd2),
                   acc_valid & (acc_axis == 2'd1),
                   acc_valid & (acc_axis == 2'd0)};

  assign cmd_fire = strobe_edge & ~cs_s & (state_q == IDLE);
  assign take_sel = {cmd_fire & (data_s == 8'h7A),
                     cmd_fire & (data_s == 8'h79),
                     cmd_fire & (data_s == 8'h78)};
`ifdef RP_AXIS_STATUS_EN
  assign status_cmd = cmd_fire & (data_s == 8'h73);
`else
  assign status_cmd = 1'b0;
`endif
  assign bad_cmd = cmd_fire & ~(|take_sel) & ~status_cmd;

  // Snapshot source reads the registers before this cycle's acc write lands.
  assign snap_d = take_sel[0] ? ax_x_q : (take_sel[1] ? ax_y_q : ax_z_q);

  // Axis sample registers; axis code 3 writes nothing.
  always_ff @(posedge CLK_50) begin
    if (!iRSTN) begin
      ax_x_q <= '0;
      ax_y_q <= '0;
      ax_z_q <= '0;
    end else begin
      if (wr_sel[0]) ax_x_q <= acc_data;
      if (wr_sel[1]) ax_y_q <= acc_data;
      if (wr_sel[2]) ax_z_q <= acc_data;
    end
  end

`ifdef RP_AXIS_STATUS_EN
  // Fresh flags: a write in the same cycle as a snapshot leaves the flag set.
  always_ff @(posedge CLK_50) begin
    if (!iRSTN) fresh_q <= '0;
    else        fresh_q <= (fresh_q & ~take_sel) | wr_sel;
  end
`endif

  // Command FSM; bus outputs are registered from the current state, so they
  // trail the state by one cycle, except CS which drops the enable at once.
  always_ff @(posedge CLK_50) begin
    if (!iRSTN) begin
      state_q       <= IDLE;
      snap_q        <= '0;
      dimension_q   <= '0;
      cmd_err_q     <= 1'b0;
      rp_data_out_q <= '0;
      rp_data_oe_q  <= 1'b0;
`ifdef RP_AXIS_STATUS_EN
      status_q      <= 1'b0;
`endif
    end else begin
      cmd_err_q <= bad_cmd;
      case (state_q)
        SEND_L: begin
          rp_data_oe_q  <= 1'b1;
          rp_data_out_q <= snap_q[7:0];
        end
        SEND_H: begin
          rp_data_oe_q  <= 1'b1;
          rp_data_out_q <= snap_q[15:8];
        end
        default: begin
          rp_data_oe_q  <= 1'b0;
          rp_data_out_q <= '0;
        end
      endcase

      if (cs_s) begin
        state_q      <= IDLE;
        rp_data_oe_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|take_sel) begin
              snap_q      <= snap_d;
              dimension_q <= take_sel[2] ? 2'd2 : (take_sel[1] ? 2'd1 : 2'd0);
              state_q     <= SEND_L;
`ifdef RP_AXIS_STATUS_EN
              status_q    <= 1'b0;
            end else if (status_cmd) begin
              snap_q      <= {8'h00, 5'b0, fresh_q};
              status_q    <= 1'b1;
              state_q     <= SEND_L;
`endif
            end
          end
          SEND_L: begin
`ifdef RP_AXIS_STATUS_EN
            if (strobe_edge) state_q <= status_q ? IDLE : SEND_H;
`else
            if (strobe_edge) state_q <= SEND_H;
`endif
          end
          SEND_H: begin
            if (strobe_edge) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rp_data_out = rp_data_out_q;
  assign rp_data_oe  = rp_data_oe_q;
  assign dimension   = dimension_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_rp_axis_server.sv
// Testbench for rp_axis_server: Pi-side driver with a byte-queue reference
// model feeding a scoreboard; a monitor checks the bus when the Pi reads it.
module tb_rp_axis_server;

  localparam int SYNC = 2;

  logic        CLK_50 = 1'b0;
  logic        iRSTN;
  logic        RP_clock;
  logic        RP_CS;
  logic [7:0]  rp_data_in;
  logic [7:0]  rp_data_out;
  logic        rp_data_oe;
  logic        acc_valid;
  logic [1:0]  acc_axis;
  logic [15:0] acc_data;
  logic [1:0]  dimension;
  logic        cmd_err;

  rp_axis_server #(.SYNC_STAGES(SYNC)) dut (
    .CLK_50      (CLK_50),
    .iRSTN       (iRSTN),
    .RP_clock    (RP_clock),
    .RP_CS       (RP_CS),
    .rp_data_in  (rp_data_in),
    .rp_data_out (rp_data_out),
    .rp_data_oe  (rp_data_oe),
    .acc_valid   (acc_valid),
    .acc_axis    (acc_axis),
    .acc_data    (acc_data),
    .dimension   (dimension),
    .cmd_err     (cmd_err)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    logic       oe;
    logic [7:0] data;
    logic [1:0] dim;
    logic       chk_data;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   tests = 0;
  int   fails = 0;
  int   exp_err = 0;
  int   err_seen = 0;
  int   err_width = 0;

  // Reference model: axis values, fresh flags, bytes still to be returned.
  logic [15:0] m_ax [3];
  bit   [2:0]  m_fr;
  logic [7:0]  m_cur[$];
  logic [1:0]  m_dim;

  task automatic push_exp(input logic oe, input logic [7:0] d, input logic [1:0] dim,
                          input logic chk, input string nm);
    exp_t e;
    e.oe = oe; e.data = d; e.dim = dim; e.chk_data = chk; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_ax[i] = 16'h0;
    m_fr  = '0;
    m_dim = 2'd0;
    m_cur.delete();
  endtask

  // Monitor: compares the bus each time the Pi samples it.
  always @(sample_ev) begin
    exp_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sample: bus read with no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if (rp_data_oe !== e.oe || ((e.oe || e.chk_data) && rp_data_out !== e.data) ||
          dimension !== e.dim || cmd_err !== 1'b0) begin
        fails++;
        $display("FAIL %s: got oe=%0b out=%02h dim=%0d err=%0b, expected oe=%0b out=%02h dim=%0d err=0",
                 e.name, rp_data_oe, rp_data_out, dimension, cmd_err, e.oe, e.data, e.dim);
      end
    end
  end

  // cmd_err pulse monitor: every pulse must be exactly one cycle wide.
  always @(negedge CLK_50) begin
    if (cmd_err === 1'b1) err_width++;
    else if (err_width > 0) begin
      tests++;
      err_seen++;
      if (err_width != 1) begin
        fails++;
        $display("FAIL cmd_err_width: got %0d cycles, expected 1", err_width);
      end
      err_width = 0;
    end
  end

  task automatic acc_write(input logic [1:0] ax, input logic [15:0] d);
    @(negedge CLK_50);
    acc_valid = 1'b1; acc_axis = ax; acc_data = d;
    if (ax != 2'd3) begin
      m_ax[ax] = d;
      m_fr[ax] = 1'b1;
    end
    @(negedge CLK_50);
    acc_valid = 1'b0;
  endtask

  // One Pi strobe carrying byte b; the Pi reads the bus late in the high phase.
  task automatic pi_strobe(input logic [7:0] b, input string nm);
    int idx;
    if (m_cur.size() > 0) begin
      void'(m_cur.pop_front());
      if (m_cur.size() > 0) push_exp(1'b1, m_cur[0], m_dim, 1'b0, nm);
      else                  push_exp(1'b0, 8'h00, m_dim, 1'b0, nm);
    end else if (b >= 8'h78 && b <= 8'h7A) begin
      idx   = int'(b) - 120;
      m_cur.push_back(m_ax[idx][7:0]);
      m_cur.push_back(m_ax[idx][15:8]);
      m_dim = 2'(idx);
      m_fr[idx] = 1'b0;
      push_exp(1'b1, m_cur[0], m_dim, 1'b0, nm);
`ifdef RP_AXIS_STATUS_EN
    end else if (b == 8'h73) begin
      m_cur.push_back({5'b0, m_fr});
      push_exp(1'b1, m_cur[0], m_dim, 1'b0, nm);
`endif
    end else begin
      exp_err++;
      push_exp(1'b0, 8'h00, m_dim, 1'b0, nm);
    end
    @(negedge CLK_50);
    rp_data_in = b;
    repeat (2) @(negedge CLK_50);
    RP_clock = 1'b1;
    repeat (8) @(negedge CLK_50);
    -> sample_ev;
    RP_clock = 1'b0;
    repeat (6) @(negedge CLK_50);
  endtask

  task automatic pi_abort(input string nm);
    @(negedge CLK_50);
    RP_CS = 1'b1;
    m_cur.delete();
    repeat (SYNC + 2) @(negedge CLK_50);
    push_exp(1'b0, 8'h00, m_dim, 1'b0, nm);
    -> sample_ev;
    repeat (2) @(negedge CLK_50);
    RP_CS = 1'b0;
    repeat (SYNC + 3) @(negedge CLK_50);
  endtask

  task automatic reset_mid();
    @(negedge CLK_50);
    iRSTN = 1'b0;
    model_reset();
    @(negedge CLK_50);
    push_exp(1'b0, 8'h00, 2'd0, 1'b1, "reset_mid");
    -> sample_ev;
    rp_data_in = 8'h78;
    RP_clock   = 1'b1;
    repeat (3) @(negedge CLK_50);
    iRSTN = 1'b1;
    repeat (10) @(negedge CLK_50);
    push_exp(1'b0, 8'h00, 2'd0, 1'b0, "no_spurious_edge");
    -> sample_ev;
    RP_clock = 1'b0;
    repeat (8) @(negedge CLK_50);
    rp_data_in = 8'h00;
  endtask

  initial begin
    logic [7:0] cmd;
    int r;
    iRSTN = 1'b0; RP_clock = 1'b0; RP_CS = 1'b0; rp_data_in = 8'h00;
    acc_valid = 1'b0; acc_axis = 2'd0; acc_data = 16'h0;
    model_reset();
    repeat (3) @(negedge CLK_50);
    push_exp(1'b0, 8'h00, 2'd0, 1'b1, "reset_state");
    -> sample_ev;
    iRSTN = 1'b1;
    repeat (5) @(negedge CLK_50);

    acc_write(2'd1, 16'hBEEF);
    pi_strobe(8'h79, "read_y_lo");
    pi_strobe(8'h00, "read_y_hi");
    pi_strobe(8'h00, "read_y_end");

    acc_write(2'd0, 16'h1234);
    pi_strobe(8'h78, "coh_lo");
    acc_write(2'd0, 16'hABCD);
    pi_strobe(8'h00, "coh_hi");
    pi_strobe(8'h00, "coh_end");
    pi_strobe(8'h78, "coh2_lo");
    pi_strobe(8'h00, "coh2_hi");
    pi_strobe(8'h00, "coh2_end");

    pi_strobe(8'h41, "bad_cmd");

    acc_write(2'd2, 16'h5A3C);
    pi_strobe(8'h7A, "abort_lo");
    pi_abort("abort_oe");
    pi_strobe(8'h7A, "after_abort_lo");
    pi_strobe(8'h00, "after_abort_hi");
    pi_strobe(8'h00, "after_abort_end");

    pi_strobe(8'h79, "rst_lo");
    pi_strobe(8'h00, "rst_hi");
    reset_mid();

    acc_write(2'd0, 16'h1111);
    acc_write(2'd2, 16'h3333);
    pi_strobe(8'h73, "status_xz");
    pi_strobe(8'h00, "status_end");
    pi_strobe(8'h78, "status_rx_lo");
    pi_strobe(8'h00, "status_rx_hi");
    pi_strobe(8'h00, "status_rx_end");
    pi_strobe(8'h73, "status_z");
    pi_strobe(8'h00, "status_end2");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        acc_write(2'($urandom_range(0, 3)), 16'($urandom));
      end else if (r <= 7) begin
        case ($urandom_range(0, 3))
          0: cmd = 8'h78;
          1: cmd = 8'h79;
          2: cmd = 8'h7A;
          default: cmd = 8'h73;
        endcase
        pi_strobe(cmd, "rnd_cmd");
        if ($urandom_range(0, 1) == 1) acc_write(2'($urandom_range(0, 3)), 16'($urandom));
        while (m_cur.size() > 0) pi_strobe(8'($urandom), "rnd_byte");
      end else if (r == 8) begin
        pi_strobe(8'h78 + 8'($urandom_range(0, 2)), "rnd_part");
        pi_abort("rnd_abort");
      end else begin
        do cmd = 8'($urandom); while ((cmd >= 8'h78 && cmd <= 8'h7A) || cmd == 8'h73);
        pi_strobe(cmd, "rnd_bad");
      end
    end

    repeat (10) @(negedge CLK_50);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d unread expectations, expected 0", exp_q.size());
    end
    tests++;
    if (err_seen != exp_err) begin
      fails++;
      $display("FAIL cmd_err_count: got %0d pulses, expected %0d", err_seen, exp_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
